// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU data port has priority, the video scan reader is
// starvation-protected by a wait counter that forces a short burst of video grants.
module mem_arbiter #(
   parameter int AW       = 15,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4,
   parameter int VBURST   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_valid,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic [DW-1:0] vid_dout,
   output logic          vid_valid,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam int BCW = $clog2(VBURST + 1);
   localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);
   localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
   localparam logic [BCW-1:0] BURST_MAX = BCW'(VBURST);
   localparam logic [BCW-1:0] BURST_ONE = BCW'(1);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_VBURST = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } owner_t;

   state_t         state_r,     state_s;
   owner_t         owner_s;
   owner_t         rd_owner_r,  rd_owner_s;
   logic [WCW-1:0] wait_cnt_r,  wait_cnt_s;
   logic [BCW-1:0] burst_cnt_r, burst_cnt_s;

   // Arbitration: pick this cycle's owner and the next FSM state / burst count.
   always_comb begin
      state_s     = state_r;
      owner_s     = OWN_NONE;
      burst_cnt_s = burst_cnt_r;
      case (state_r)
         ST_NORMAL: begin
            burst_cnt_s = {BCW{1'b0}};
            if (cpu_req && vid_req) begin
               if (wait_cnt_r == WAIT_MAX) begin
                  // Starvation win counts as the first grant of the burst.
                  owner_s = OWN_VID;
                  if (BURST_MAX > BURST_ONE) begin
                     state_s     = ST_VBURST;
                     burst_cnt_s = BURST_ONE;
                  end else begin
                     state_s     = ST_NORMAL;
                  end
               end else begin
                  owner_s = OWN_CPU;
               end
            end else if (cpu_req) begin
               owner_s = OWN_CPU;
            end else if (vid_req) begin
               owner_s = OWN_VID;
            end else begin
               owner_s = OWN_NONE;
            end
         end
         ST_VBURST: begin
            if (vid_req && (burst_cnt_r < BURST_MAX)) begin
               owner_s = OWN_VID;
               if ((burst_cnt_r + BURST_ONE) == BURST_MAX) begin
                  state_s     = ST_NORMAL;
                  burst_cnt_s = {BCW{1'b0}};
               end else begin
                  state_s     = ST_VBURST;
                  burst_cnt_s = burst_cnt_r + BURST_ONE;
               end
            end else begin
               state_s     = ST_NORMAL;
               burst_cnt_s = {BCW{1'b0}};
               if (cpu_req) begin
                  owner_s = OWN_CPU;
               end else begin
                  owner_s = OWN_NONE;
               end
            end
         end
         default: begin
            state_s     = ST_NORMAL;
            owner_s     = OWN_NONE;
            burst_cnt_s = {BCW{1'b0}};
         end
      endcase
   end

   // Video starvation counter and read-return tag for the granted access.
   always_comb begin
      wait_cnt_s = wait_cnt_r;
      rd_owner_s = OWN_NONE;
      if (owner_s == OWN_VID) begin
         wait_cnt_s = {WCW{1'b0}};
      end else if (vid_req && (wait_cnt_r < WAIT_MAX)) begin
         wait_cnt_s = wait_cnt_r + WAIT_ONE;
      end else begin
         wait_cnt_s = wait_cnt_r;
      end
      case (owner_s)
         OWN_CPU: begin
            if (cpu_we) begin
               rd_owner_s = OWN_NONE;
            end else begin
               rd_owner_s = OWN_CPU;
            end
         end
         OWN_VID:  rd_owner_s = OWN_VID;
         default:  rd_owner_s = OWN_NONE;
      endcase
   end

   // RAM port mux driven by the current owner; video never writes.
   always_comb begin
      mem_addr = {AW{1'b0}};
      mem_we   = 1'b0;
      case (owner_s)
         OWN_CPU: begin
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
         end
         OWN_VID: begin
            mem_addr = vid_addr;
            mem_we   = 1'b0;
         end
         default: begin
            mem_addr = {AW{1'b0}};
            mem_we   = 1'b0;
         end
      endcase
   end

   // State, counters and read tag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_NORMAL;
         wait_cnt_r  <= {WCW{1'b0}};
         burst_cnt_r <= {BCW{1'b0}};
         rd_owner_r  <= OWN_NONE;
      end else begin
         state_r     <= state_s;
         wait_cnt_r  <= wait_cnt_s;
         burst_cnt_r <= burst_cnt_s;
         rd_owner_r  <= rd_owner_s;
      end
   end

   assign mem_din   = cpu_din;
   assign cpu_stall = cpu_req & (owner_s != OWN_CPU);
   assign vid_gnt   = (owner_s == OWN_VID);
   assign cpu_valid = (rd_owner_r == OWN_CPU);
   assign vid_valid = (rd_owner_r == OWN_VID);
   assign cpu_dout  = mem_dout;
   assign vid_dout  = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench-owned RAM, a cycle model of the arbitration
// rules checked every negedge, plus literal expectations for the key scenarios.
module tb_mem_arbiter;

   localparam int AW       = 15;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 4;
   localparam int VBURST   = 2;

   logic          clk;
   logic          rst_n;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic          cpu_stall;
   logic [DW-1:0] cpu_dout;
   logic          cpu_valid;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_gnt;
   logic [DW-1:0] vid_dout;
   logic          vid_valid;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int   n_chk  = 0;
   int   n_pass = 0;
   logic chk_on = 1'b0;

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .VBURST(VBURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_stall(cpu_stall), .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_dout(vid_dout), .vid_valid(vid_valid),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 15'h0010)      return 16'hBEEF;
      else if (a == 15'h4000) return 16'h00FF;
      else                    return {1'b0, a} ^ 16'h3C5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic chk_str(input string nm, input string act, input string exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %s, expected %s", nm, act, exp);
   endtask

   // Synchronous RAM with one-cycle read latency.
   logic [DW-1:0] ram [0:32767];
   initial begin
      mem_dout = 16'h0000;
      for (int i = 0; i < 32768; i++) ram[i] = init_val(15'(i));
      forever begin
         @(posedge clk);
         mem_dout <= ram[mem_addr];
         if (mem_we) ram[mem_addr] <= mem_din;
      end
   end

   // Reference model: owner from the arbitration rules, RAM contents from granted writes.
   int            m_wait  = 0;
   int            m_bleft = 0;
   logic          exp_cv  = 1'b0;
   logic          exp_vv  = 1'b0;
   logic [DW-1:0] exp_d   = 16'h0000;
   logic [DW-1:0] wr_map [int];

   initial begin
      int            own;
      logic [AW-1:0] ea;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            if (!rst_n) begin
               m_wait = 0; m_bleft = 0; exp_cv = 1'b0; exp_vv = 1'b0;
               chk("m_rst_cpu_valid", 32'(cpu_valid), 32'h0);
               chk("m_rst_vid_valid", 32'(vid_valid), 32'h0);
            end else begin
               chk("m_cpu_valid", 32'(cpu_valid), 32'(exp_cv));
               chk("m_vid_valid", 32'(vid_valid), 32'(exp_vv));
               if (exp_cv) chk("m_cpu_dout", 32'(cpu_dout), 32'(exp_d));
               if (exp_vv) chk("m_vid_dout", 32'(vid_dout), 32'(exp_d));
               own = 0;
               if (m_bleft > 0 && vid_req) begin
                  own = 2; m_bleft = m_bleft - 1;
               end else if (m_bleft > 0) begin
                  own = cpu_req ? 1 : 0; m_bleft = 0;
               end else if (vid_req && (!cpu_req || m_wait >= MAX_WAIT)) begin
                  own = 2;
                  if (cpu_req) m_bleft = VBURST - 1;
               end else if (cpu_req) begin
                  own = 1;
               end
               if (own == 2) m_wait = 0;
               else if (vid_req && m_wait < MAX_WAIT) m_wait = m_wait + 1;
               ea = (own == 1) ? cpu_addr : (own == 2) ? vid_addr : 15'h0000;
               chk("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && own != 1));
               chk("m_vid_gnt",   32'(vid_gnt),   32'(own == 2));
               chk("m_mem_addr",  32'(mem_addr),  32'(ea));
               chk("m_mem_we",    32'(mem_we),    32'(own == 1 && cpu_we));
               chk("m_mem_din",   32'(mem_din),   32'(cpu_din));
               exp_cv = (own == 1) && !cpu_we;
               exp_vv = (own == 2);
               exp_d  = wr_map.exists(int'(ea)) ? wr_map[int'(ea)] : init_val(ea);
               if (own == 1 && cpu_we) wr_map[int'(cpu_addr)] = cpu_din;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic string letter();
      if (vid_gnt && cpu_stall)        return "V";
      else if (!vid_gnt && !cpu_stall) return "C";
      else                             return "?";
   endfunction

   initial begin
      string s;
      rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0000; cpu_din = 16'h0000;
      vid_req = 1'b0; vid_addr = 15'h0000;
      #1 rst_n = 1'b0;
      chk_on = 1'b1;
      tick();
      chk("rst_mem_we",    32'(mem_we),    32'h0);
      chk("rst_mem_addr",  32'(mem_addr),  32'h0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
      chk("rst_vid_gnt",   32'(vid_gnt),   32'h0);
      tick();
      rst_n = 1'b1;

      // CPU read of a preloaded word
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
      #1 chk("cpu_rd_stall", 32'(cpu_stall), 32'h0);
      tick();
      cpu_req = 1'b0;
      chk("cpu_rd_valid", 32'(cpu_valid), 32'h1);
      chk("cpu_rd_dout",  32'(cpu_dout),  32'hBEEF);

      // CPU write: RAM write enable, no read return
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0011; cpu_din = 16'h1234;
      #1 chk("cpu_wr_mem_we", 32'(mem_we), 32'h1);
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      chk("cpu_wr_no_valid", 32'(cpu_valid), 32'h0);

      // Video-only read
      vid_req = 1'b1; vid_addr = 15'h4000;
      #1 chk("vid_gnt", 32'(vid_gnt), 32'h1);
      tick();
      vid_req = 1'b0;
      chk("vid_valid", 32'(vid_valid), 32'h1);
      chk("vid_dout",  32'(vid_dout),  32'h00FF);
      tick();

      // Continuous contention
      cpu_req = 1'b1; cpu_addr = 15'h0100; vid_req = 1'b1; vid_addr = 15'h4100;
      s = "";
      repeat (12) begin #1 s = {s, letter()}; tick(); end
      chk_str("starve_pattern", s, "CCCCVVCCCCVV");
      cpu_req = 1'b0; vid_req = 1'b0;
      tick();

      // Burst cut short by video dropping its request
      cpu_req = 1'b1; vid_req = 1'b1;
      s = "";
      repeat (5) begin #1 s = {s, letter()}; tick(); end
      vid_req = 1'b0;
      #1 s = {s, letter()}; tick();
      vid_req = 1'b1;
      repeat (5) begin #1 s = {s, letter()}; tick(); end
      chk_str("burst_cut_pattern", s, "CCCCVCCCCCV");
      cpu_req = 1'b0; vid_req = 1'b0;
      tick(); tick();

      // Write then read-back with video contending
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0200; cpu_din = 16'hAAAA;
      vid_req = 1'b1; vid_addr = 15'h4200;
      tick();
      cpu_we = 1'b0;
      chk("rw_wr_no_cpu_valid", 32'(cpu_valid), 32'h0);
      chk("rw_wr_no_vid_valid", 32'(vid_valid), 32'h0);
      tick();
      cpu_req = 1'b0; vid_req = 1'b0;
      chk("rw_rd_valid",   32'(cpu_valid), 32'h1);
      chk("rw_rd_dout",    32'(cpu_dout),  32'hAAAA);
      chk("rw_no_vid_tag", 32'(vid_valid), 32'h0);
      tick();

      // Reset asserted while a read is in flight
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
      @(negedge clk);
      #1 rst_n = 1'b0; cpu_req = 1'b0;
      tick();
      chk("rst_mid_cpu_valid", 32'(cpu_valid), 32'h0);
      chk("rst_mid_vid_valid", 32'(vid_valid), 32'h0);
      tick();
      rst_n = 1'b1;

      // Cleared wait counter: full four CPU grants before video wins
      cpu_req = 1'b1; vid_req = 1'b1; cpu_addr = 15'h0300; vid_addr = 15'h4300;
      s = "";
      repeat (5) begin #1 s = {s, letter()}; tick(); end
      chk_str("post_rst_pattern", s, "CCCCV");
      cpu_req = 1'b0; vid_req = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
